// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the core-to-memory port arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DRAIN_I = 2'd3
  } arb_state_t;

  // Default number of back-to-back data grants tolerated while fetch waits.
  localparam int DEF_FETCH_STARVE_MAX = 4;

  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef logic [3:0] mlen_t;
  localparam mlen_t MLEN1 = 4'd0;

  typedef logic [1:0] axi_burst_t;
  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/mem_bus_arbiter_arb_req_mux.sv
// Formats the selected ibus/dbus request as a cbus request and picks the
// 32-bit fetch word out of the 64-bit memory response.
module arb_req_mux
  import mem_bus_arbiter_pkg::*;
(
  input  logic        sel_data,
  input  ibus_req_t   ireq,
  input  dbus_req_t   dreq,
  input  logic        word_hi,
  input  logic [63:0] rdata,
  output cbus_req_t   req,
  output logic [31:0] fetch_word
);

  // Request formatting: data side passes through, fetch is a 4-byte read.
  always_comb begin
    req = '0;
    if (sel_data) begin
      req.valid    = dreq.valid;
      req.is_write = |dreq.strobe;
      req.size     = dreq.size;
      req.addr     = dreq.addr;
      req.strobe   = dreq.strobe;
      req.data     = dreq.data;
    end else begin
      req.valid    = ireq.valid;
      req.is_write = 1'b0;
      req.size     = MSIZE4;
      req.addr     = ireq.addr;
      req.strobe   = 8'h00;
      req.data     = 64'h0;
    end
    req.len   = MLEN1;
    req.burst = AXI_BURST_FIXED;
  end

  // Instruction word lives in the upper half when addr[2] is set.
  assign fetch_word = word_hi ? rdata[63:32] : rdata[31:0];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Non-preemptive arbiter sharing one memory port between fetch and data,
// data first, with a bounded-starvation counter guaranteeing fetch progress.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int FETCH_STARVE_MAX = mem_bus_arbiter_pkg::DEF_FETCH_STARVE_MAX,
  parameter int CNT_W            = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp,
  input  logic       ifetch_kill
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FETCH_STARVE_MAX);

  arb_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  cbus_req_t        req_reg;

  logic       grant_d;
  logic       grant_i;
  logic       done;
  cbus_req_t  mux_req;
  logic [31:0] fetch_word;

  // Data wins unless fetch is waiting and has already been passed over MAX times.
  assign grant_d = dreq.valid && !(ireq.valid && (cnt_reg == CNT_MAX));
  assign grant_i = !grant_d && ireq.valid;
  assign done    = oresp.ready && oresp.last && (state_reg != IDLE);

  arb_req_mux u_req_mux (
    .sel_data   (grant_d),
    .ireq       (ireq),
    .dreq       (dreq),
    .word_hi    (req_reg.addr[2]),
    .rdata      (oresp.data),
    .req        (mux_req),
    .fetch_word (fetch_word)
  );

  // Arbitration FSM, request latch and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      req_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            state_reg <= GRANT_D;
            req_reg   <= mux_req;
            if (!ireq.valid)
              cnt_reg <= '0;
            else if (cnt_reg != CNT_MAX)
              cnt_reg <= cnt_reg + 1'b1;
          end else if (grant_i) begin
            state_reg <= GRANT_I;
            req_reg   <= mux_req;
            cnt_reg   <= '0;
          end
        end
        GRANT_I: begin
          if (done) begin
            state_reg     <= IDLE;
            req_reg.valid <= 1'b0;
          end else if (ifetch_kill) begin
            state_reg <= DRAIN_I;
          end
        end
        GRANT_D, DRAIN_I: begin
          if (done) begin
            state_reg     <= IDLE;
            req_reg.valid <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign oreq = req_reg;

  // Only the owning side sees the completion; a kill in that cycle suppresses fetch.
  always_comb begin
    iresp         = '0;
    dresp         = '0;
    iresp.data    = fetch_word;
    dresp.data    = oresp.data;
    iresp.addr_ok = done && (state_reg == GRANT_I) && !ifetch_kill;
    iresp.data_ok = iresp.addr_ok;
    dresp.addr_ok = done && (state_reg == GRANT_D);
    dresp.data_ok = dresp.addr_ok;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then random traffic, all
// checked cycle by cycle against a transaction-level ownership model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int STARVE = 4;

  logic       clk = 1'b0;
  logic       rst;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic       ifetch_kill;

  int checks   = 0;
  int failures = 0;

  // Model: who owns the port (0 none, 1 fetch, 2 data) and what it asked for.
  int          m_owner = 0;
  bit          m_drain = 0;
  int          m_cnt   = 0;
  bit          m_known = 0;
  logic [63:0] m_addr;
  logic        m_wr;
  logic [2:0]  m_size;
  logic [7:0]  m_strb;
  logic [63:0] m_data;

  mem_bus_arbiter #(.FETCH_STARVE_MAX(STARVE), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .ireq        (ireq),
    .iresp       (iresp),
    .dreq        (dreq),
    .dresp       (dresp),
    .oreq        (oreq),
    .oresp       (oresp),
    .ifetch_kill (ifetch_kill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rst         = 1'b0;
    ireq        = '0;
    dreq        = '0;
    oresp       = '0;
    ifetch_kill = 1'b0;
  endtask

  // Compare every output against the model with the current inputs applied.
  task automatic check_cycle();
    bit done_m;
    bit i_ok;
    bit d_ok;
    #1;
    if (m_known) begin
      done_m = (m_owner != 0) && oresp.ready && oresp.last;
      i_ok   = done_m && (m_owner == 1) && !m_drain && !ifetch_kill;
      d_ok   = done_m && (m_owner == 2);
      chk("oreq_valid", oreq.valid, m_owner != 0);
      if (m_owner != 0) begin
        chk("oreq_addr",  oreq.addr, m_addr);
        chk("oreq_wr",    oreq.is_write, m_wr);
        chk("oreq_size",  oreq.size, m_size);
        chk("oreq_strb",  oreq.strobe, m_strb);
        chk("oreq_len",   oreq.len, MLEN1);
        chk("oreq_burst", oreq.burst, AXI_BURST_FIXED);
        if (m_owner == 2) chk("oreq_data", oreq.data, m_data);
      end
      chk("iresp_addr_ok", iresp.addr_ok, i_ok);
      chk("iresp_data_ok", iresp.data_ok, i_ok);
      chk("dresp_addr_ok", dresp.addr_ok, d_ok);
      chk("dresp_data_ok", dresp.data_ok, d_ok);
      if (i_ok) chk("iresp_data", iresp.data,
                    m_addr[2] ? {32'h0, oresp.data[63:32]} : {32'h0, oresp.data[31:0]});
      if (d_ok) chk("dresp_data", dresp.data, oresp.data);
    end
  endtask

  // Apply the arbitration rules to the inputs of this cycle, then clock.
  task automatic advance();
    bit done_m;
    done_m = (m_owner != 0) && oresp.ready && oresp.last;
    if (rst) begin
      m_owner = 0; m_drain = 0; m_cnt = 0; m_known = 1;
    end else if (m_known) begin
      if (m_owner == 0) begin
        if (dreq.valid && !(ireq.valid && m_cnt == STARVE)) begin
          m_owner = 2;
          m_addr = dreq.addr; m_wr = (dreq.strobe != 0); m_size = dreq.size;
          m_strb = dreq.strobe; m_data = dreq.data;
          m_cnt = ireq.valid ? ((m_cnt + 1 > STARVE) ? STARVE : m_cnt + 1) : 0;
        end else if (ireq.valid) begin
          m_owner = 1;
          m_addr = ireq.addr; m_wr = 1'b0; m_size = MSIZE4; m_strb = 8'h00;
          m_cnt = 0;
        end
      end else if (done_m) begin
        m_owner = 0; m_drain = 0;
      end else if (m_owner == 1 && ifetch_kill) begin
        m_drain = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    check_cycle();
    advance();
  endtask

  initial begin
    logic [5:0] seq;
    int   nseen;
    logic prev_v;

    idle_inputs();
    @(negedge clk);

    // Reset and idle state.
    rst = 1'b1; step(); step();
    rst = 1'b0; step();
    $display("txn reset: idle state checked");

    // Fetch only, upper word selected by addr[2].
    ireq.valid = 1'b1; ireq.addr = 64'h8000_0004;
    step();
    ireq.valid = 1'b0;
    check_cycle(); chk("t1_size", oreq.size, MSIZE4); chk("t1_wr", oreq.is_write, 0); advance();
    step();
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 64'h1111_2222_3333_4444;
    check_cycle(); chk("t1_ok", iresp.data_ok, 1); chk("t1_word", iresp.data, 32'h1111_2222);
    chk("t1_dok", dresp.data_ok, 0); advance();
    idle_inputs(); step();
    $display("txn fetch: addr=%h", 64'h8000_0004);

    // Simultaneous requests: data store first, fetch right after.
    ireq.valid = 1'b1; ireq.addr = 64'h8000_0008;
    dreq.valid = 1'b1; dreq.addr = 64'h8000_1000; dreq.size = MSIZE4;
    dreq.strobe = 8'h0F; dreq.data = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    check_cycle(); chk("t2_wr", oreq.is_write, 1); chk("t2_strb", oreq.strobe, 8'h0F); advance();
    dreq.valid = 1'b0; oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 64'h55;
    check_cycle(); chk("t2_dok", dresp.data_ok, 1); advance();
    oresp = '0; step();
    check_cycle(); chk("t2_fetch", oreq.valid, 1); chk("t2_faddr", oreq.addr, 64'h8000_0008); advance();
    ireq.valid = 1'b0; oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    idle_inputs(); step();
    $display("txn priority: data then fetch");

    // Starvation bound: D,D,D,D,I,D with memory answering immediately.
    ireq.valid = 1'b1; ireq.addr = 64'h8000_0010;
    dreq.valid = 1'b1; dreq.addr = 64'h8000_2000; dreq.size = MSIZE8; dreq.strobe = 8'hFF;
    dreq.data = 64'h1234;
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 64'h0;
    seq = '0; nseen = 0; prev_v = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check_cycle();
      if (oreq.valid && !prev_v && nseen < 6) begin
        seq = {seq[4:0], oreq.is_write};
        nseen++;
      end
      prev_v = oreq.valid;
      advance();
    end
    chk("t3_ngrants", nseen, 6);
    chk("t3_seq", seq, 6'b111101);
    idle_inputs(); step();
    $display("txn starve: grant pattern=%b", seq);

    // Kill right after a fetch grant: drain, no response, data next.
    ireq.valid = 1'b1; ireq.addr = 64'h0000_0100;
    step();
    ireq.valid = 1'b0; ifetch_kill = 1'b1;
    step();
    ifetch_kill = 1'b0;
    check_cycle(); chk("t4_held", oreq.valid, 1); advance();
    dreq.valid = 1'b1; dreq.addr = 64'h0000_2000; dreq.size = MSIZE8; dreq.strobe = 8'h00;
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 64'h77;
    check_cycle(); chk("t4_no_ok", iresp.data_ok, 0); advance();
    oresp = '0; step();
    check_cycle(); chk("t4_dgrant", oreq.valid, 1); chk("t4_daddr", oreq.addr, 64'h2000); advance();
    dreq.valid = 1'b0; oresp.ready = 1'b1; oresp.last = 1'b1;
    step();
    idle_inputs(); step();
    $display("txn kill: fetch drained");

    // Reset while a data transaction is outstanding.
    dreq.valid = 1'b1; dreq.addr = 64'h0000_3000; dreq.size = MSIZE2; dreq.strobe = 8'h03;
    step();
    dreq.valid = 1'b0; step();
    rst = 1'b1; step();
    rst = 1'b0; oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 64'h99;
    check_cycle(); chk("t5_valid", oreq.valid, 0); chk("t5_dok", dresp.data_ok, 0); advance();
    idle_inputs(); step();
    $display("txn reset_mid: late response ignored");

    // Data request withdrawn before its grant: fetch served instead.
    ireq.valid = 1'b1; ireq.addr = 64'h0000_4000;
    step();
    dreq.valid = 1'b1; dreq.addr = 64'h0000_5000; dreq.strobe = 8'hFF; step();
    oresp.ready = 1'b1; oresp.last = 1'b1; step();
    oresp = '0; dreq.valid = 1'b0; step();
    check_cycle(); chk("t6_fetch", oreq.is_write, 0); chk("t6_size", oreq.size, MSIZE4); advance();
    ireq.valid = 1'b0; oresp.ready = 1'b1; oresp.last = 1'b1; step();
    idle_inputs(); step();
    $display("txn withdraw: fetch granted");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(255) == 0);
      ireq.valid     = ($urandom_range(9) < 6);
      ireq.addr      = {$urandom, $urandom};
      dreq.valid     = ($urandom_range(1) == 1);
      dreq.addr      = {$urandom, $urandom};
      dreq.size      = 3'($urandom_range(3));
      dreq.strobe    = ($urandom_range(1) == 1) ? 8'($urandom) : 8'h00;
      dreq.data      = {$urandom, $urandom};
      ifetch_kill    = ($urandom_range(9) == 0);
      oresp.ready    = ($urandom_range(2) == 0);
      oresp.last     = oresp.ready ? ($urandom_range(3) != 0) : ($urandom_range(1) == 1);
      oresp.data     = {$urandom, $urandom};
      step();
    end
    $display("txn random: 3000 cycles");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
